// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between IF and MEM, MEM first
// Serializes accesses, captures read data per requester and raises Stall until all are served.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IFReq,
    input  logic [31:0] IFAddr,
    output logic [31:0] IFRdata,
    output logic        IFReady,
    input  logic        EXMEMMemRead,
    input  logic        EXMEMMemWrite,
    input  logic [31:0] EXMEMALUResult,
    input  logic [31:0] EXMEMWriteData,
    output logic [31:0] MEMReadData,
    output logic        MEMReady,
    output logic        MemoryEn,
    output logic        MemoryWe,
    output logic [31:0] MemoryAddr,
    output logic [31:0] MemoryWdata,
    input  logic [31:0] MemoryRdata,
    output logic        Stall
);

    typedef enum logic [1:0] {IDLE, BUSY_MEM, BUSY_IF} stateType;

    localparam logic [3:0] LoadCount = 4'(LATENCY);

    stateType   state;
    stateType   nextState;
    logic [3:0] cnt;
    logic       memReq;
    logic       memPend;
    logic       ifPend;
    logic       accessDone;
    logic       startMem;
    logic       startIf;

    always_comb begin
        memReq     = EXMEMMemRead | EXMEMMemWrite;
        memPend    = memReq & ~MEMReady;
        ifPend     = IFReq & ~IFReady;
        accessDone = (state != IDLE) && (cnt == 4'd1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // On completion the other requester goes straight onto the port if it is still waiting.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (memPend) begin
                    nextState = BUSY_MEM;
                end else if (ifPend) begin
                    nextState = BUSY_IF;
                end
            end
            BUSY_MEM: begin
                if (accessDone) begin
                    nextState = ifPend ? BUSY_IF : IDLE;
                end
            end
            BUSY_IF: begin
                if (accessDone) begin
                    nextState = memPend ? BUSY_MEM : IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        Stall    = memPend | ifPend;
        startMem = (nextState == BUSY_MEM) && (state != BUSY_MEM);
        startIf  = (nextState == BUSY_IF) && (state != BUSY_IF);
    end

    // Address and data are sampled only when an access starts and held until it retires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= 4'd0;
            MemoryEn    <= 1'b0;
            MemoryWe    <= 1'b0;
            MemoryAddr  <= 32'd0;
            MemoryWdata <= 32'd0;
        end else if (startMem || startIf) begin
            cnt         <= LoadCount;
            MemoryEn    <= 1'b1;
            MemoryWe    <= startMem & EXMEMMemWrite;
            MemoryAddr  <= startMem ? EXMEMALUResult : IFAddr;
            MemoryWdata <= EXMEMWriteData;
        end else if (accessDone) begin
            cnt      <= 4'd0;
            MemoryEn <= 1'b0;
            MemoryWe <= 1'b0;
        end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Ready flags stay up until the pipeline advances or the request goes away.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MEMReady    <= 1'b0;
            MEMReadData <= 32'd0;
            IFReady     <= 1'b0;
            IFRdata     <= 32'd0;
        end else begin
            if (accessDone && state == BUSY_MEM) begin
                MEMReady <= 1'b1;
                if (!MemoryWe) begin
                    MEMReadData <= MemoryRdata;
                end
            end else if (!Stall || !memReq) begin
                MEMReady <= 1'b0;
            end
            if (accessDone && state == BUSY_IF) begin
                IFReady <= 1'b1;
                IFRdata <= MemoryRdata;
            end else if (!Stall || !IFReq) begin
                IFReady <= 1'b0;
            end
        end
    end

endmodule
